// File: rtl/hadamard_stream_feeder_if.sv
// Valid/ready stream bundle carrying 4-lane complex samples, twiddles and a frame-last flag.
interface hadamard_stream_feeder_if #(
  parameter int unsigned formatWidth = 9
);
  localparam int unsigned LW = 4 * formatWidth;

  logic          valid;
  logic          ready;
  logic          last;
  logic [LW-1:0] data_real;
  logic [LW-1:0] data_imag;
  logic [LW-1:0] tw_real;
  logic [LW-1:0] tw_imag;

  modport master (
    output valid, last, data_real, data_imag, tw_real, tw_imag,
    input  ready
  );

  modport slave (
    input  valid, last, data_real, data_imag, tw_real, tw_imag,
    output ready
  );
endinterface

// File: rtl/hadamard_stream_feeder.sv
// Stream feeder for the 4-lane complex Hadamard/twiddle engine: drives the free-running
// pipeline, recovers results by a tag delay line and buffers them in a credit-protected FIFO.
module hadamard_stream_feeder #(
  parameter int unsigned formatWidth = 9,
  parameter int unsigned PIPE_LAT    = 5,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hadamard_stream_feeder_if.slave  s,
  output logic [4*formatWidth-1:0] eng_in_real,
  output logic [4*formatWidth-1:0] eng_in_imag,
  output logic [4*formatWidth-1:0] eng_tw_real,
  output logic [4*formatWidth-1:0] eng_tw_imag,
  output logic                     eng_start,
  input  logic [4*formatWidth-1:0] eng_out_real,
  input  logic [4*formatWidth-1:0] eng_out_imag,
  hadamard_stream_feeder_if.master m,
  output logic                     busy,
  output logic [CNT_W-1:0]         frame_cnt
);
  localparam int unsigned LW = 4 * formatWidth;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     in_real_q, in_imag_q, tw_real_q, tw_imag_q;
  logic              start_q;
  logic [PIPE_LAT:0] tag_v_q, tag_l_q;
  logic [LW-1:0]     mem_real_q [FIFO_DEPTH];
  logic [LW-1:0]     mem_imag_q [FIFO_DEPTH];
  logic              mem_last_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, inflight;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic s_ready, m_valid, acc, pop, push, head_last, credit_ok, frame_done;

  // Every set tag bit is a beat that will land in the FIFO, so it holds a slot already.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= PIPE_LAT; i++) inflight = inflight + CW'(tag_v_q[i]);
  end

  assign credit_ok = ({1'b0, inflight} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);
  assign m_valid   = (count_q != '0);
  assign head_last = mem_last_q[rd_ptr_q];
  assign acc       = s.valid & s_ready;
  assign pop       = m_valid & m.ready;
  assign push      = tag_v_q[PIPE_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = s.last ? DRAIN : RUN;
      RUN:     if (acc && s.last) state_d = DRAIN;
      DRAIN:   if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = (state_q != DRAIN) && credit_ok;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DRAIN) && pop && head_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_real_q <= '0;
      in_imag_q <= '0;
      tw_real_q <= '0;
      tw_imag_q <= '0;
      start_q   <= 1'b0;
      tag_v_q   <= '0;
      tag_l_q   <= '0;
    end else begin
      start_q <= acc;
      if (acc) begin
        in_real_q <= s.data_real;
        in_imag_q <= s.data_imag;
        tw_real_q <= s.tw_real;
        tw_imag_q <= s.tw_imag;
      end
      tag_v_q <= {tag_v_q[PIPE_LAT-1:0], acc};
      tag_l_q <= {tag_l_q[PIPE_LAT-1:0], s.last};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_real_q[i] <= '0;
        mem_imag_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_real_q[wr_ptr_q] <= eng_out_real;
        mem_imag_q[wr_ptr_q] <= eng_out_imag;
        mem_last_q[wr_ptr_q] <= tag_l_q[PIPE_LAT];
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (frame_done) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(push && (count_q == CW'(FIFO_DEPTH))));

  assign s.ready     = s_ready;
  assign eng_in_real = in_real_q;
  assign eng_in_imag = in_imag_q;
  assign eng_tw_real = tw_real_q;
  assign eng_tw_imag = tw_imag_q;
  assign eng_start   = start_q;
  assign m.valid     = m_valid;
  assign m.data_real = mem_real_q[rd_ptr_q];
  assign m.data_imag = mem_imag_q[rd_ptr_q];
  assign m.last      = head_last;
  assign m.tw_real   = '0;
  assign m.tw_imag   = '0;
  assign frame_cnt   = frame_cnt_q;
endmodule
